// File: rtl/td4_pkg.sv
// -----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 run/step sequencer:
//   - run_state_t : sequencer FSM state encoding
//   - PC_W/LOAD_W : program counter and load-strobe widths
//   - LD_*        : bit positions inside the active-low load-strobe vector
//   - LOAD_IDLE   : all load strobes deasserted
//   - is_self_jump: detects the "jump to myself" end-of-program idiom
// -----------------------------------------------------------------------------
package td4_pkg;

    localparam int PC_W   = 4;
    localparam int LOAD_W = 4;

    localparam int LD_A   = 0;
    localparam int LD_B   = 1;
    localparam int LD_OUT = 2;
    localparam int LD_PC  = 3;

    localparam logic [LOAD_W-1:0] LOAD_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_LOCKED  = 2'd3
    } run_state_t;

    // A jump (PC load strobe low) whose target is the current PC never
    // leaves that address again, so it marks the end of the program.
    function automatic logic is_self_jump(
        input logic [LOAD_W-1:0] load_n,
        input logic [PC_W-1:0]   imm,
        input logic [PC_W-1:0]   pc
    );
        return (load_n[LD_PC] == 1'b0) && (imm == pc);
    endfunction

endpackage

// File: rtl/td4_tick_gen.sv
// -----------------------------------------------------------------------------
// td4_tick_gen
// Produces the one-cycle execute TICK for the run controller.
//   Run mode  (RUN_MODE=1): divider counts 0..TICK_DIV-1, TICK when at the top.
//   Step mode (RUN_MODE=0): STEP is synchronized (2 flops) and rising-edge
//                           detected (1 flop); TICK on a synchronized rise.
//   Any RUN_MODE change clears the divider and discards a pending step edge.
// Ports:
//   CLK      in  system clock
//   N_RESET  in  synchronous active-low reset
//   RUN_MODE in  1 = free run, 0 = single step
//   STEP     in  raw step button, asynchronous to CLK
//   TICK     out one-cycle execute request
// -----------------------------------------------------------------------------
module td4_tick_gen
    import td4_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int DIV_W    = 24
) (
    input  logic CLK,
    input  logic N_RESET,
    input  logic RUN_MODE,
    input  logic STEP,
    output logic TICK
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_edge;
    logic             r_mode_prev;
    logic             w_mode_change;
    logic             w_run_tick;
    logic             w_step_tick;

    assign w_mode_change = (RUN_MODE != r_mode_prev);
    assign w_run_tick    = (r_div == DIV_LAST);
    assign w_step_tick   = r_sync2 & ~r_edge;

    // The cycle in which the mode flips never produces a tick.
    assign TICK = !w_mode_change && (RUN_MODE ? w_run_tick : w_step_tick);

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_div       <= '0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_edge      <= 1'b0;
            // Track the live mode so leaving reset is not seen as a change.
            r_mode_prev <= RUN_MODE;
        end else begin
            r_mode_prev <= RUN_MODE;
            r_sync1     <= STEP;
            r_sync2     <= r_sync1;
            if (w_mode_change) begin
                r_div  <= '0;
                // Align the edge flop with the level already in flight so a
                // press captured before the mode flip cannot fire afterwards.
                r_edge <= r_sync1;
            end else begin
                r_edge <= r_sync2;
                if (!RUN_MODE || w_run_tick) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/td4_run_control.sv
// -----------------------------------------------------------------------------
// td4_run_control
// Run/step sequencer for the 4-bit TD4 core. Owns PC and the carry flag and
// opens a one-cycle execute window per tick, during which the decoder's
// active-low load strobes are passed to the registers.
// Ports:
//   CLK        in  system clock
//   N_RESET    in  synchronous active-low reset
//   RUN_MODE   in  1 = free run from divider, 0 = single step via STEP
//   STEP       in  raw step button level
//   HALT_REQ   in  pause request (level)
//   LOAD_IN    in  decoder load strobes, active-low, [3] = PC load
//   IMM        in  instruction immediate / jump target
//   ALU_CARRY  in  adder carry-out of the current instruction
//   PC         out program counter
//   LOAD_N_EN  out gated load strobes, active-low
//   EXEC       out one-cycle execute strobe
//   CARRY_FLAG out registered carry
//   HALTED     out high while paused
//   DONE       out sticky end-of-program (self-jump executed)
// -----------------------------------------------------------------------------
module td4_run_control
    import td4_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int DIV_W    = 24
) (
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              RUN_MODE,
    input  logic              STEP,
    input  logic              HALT_REQ,
    input  logic [LOAD_W-1:0] LOAD_IN,
    input  logic [PC_W-1:0]   IMM,
    input  logic              ALU_CARRY,
    output logic [PC_W-1:0]   PC,
    output logic [LOAD_W-1:0] LOAD_N_EN,
    output logic              EXEC,
    output logic              CARRY_FLAG,
    output logic              HALTED,
    output logic              DONE
);

    run_state_t      r_state;
    run_state_t      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic            r_carry;
    logic            r_done;
    logic            w_tick;
    logic            w_self_jump;

    td4_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .RUN_MODE (RUN_MODE),
        .STEP     (STEP),
        .TICK     (w_tick)
    );

    assign w_self_jump = is_self_jump(LOAD_IN, IMM, r_pc);

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ticks are only consumed in WAIT; in EXECUTE, PAUSE and LOCKED they are
    // simply ignored, which is what drops them.
    always_comb begin
        w_state_next = r_state;
        EXEC         = 1'b0;
        LOAD_N_EN    = LOAD_IDLE;
        HALTED       = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (HALT_REQ) begin
                    w_state_next = ST_PAUSE;
                end else if (w_tick) begin
                    w_state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                EXEC      = 1'b1;
                LOAD_N_EN = LOAD_IN;
                w_state_next = w_self_jump ? ST_LOCKED : ST_WAIT;
            end
            ST_PAUSE: begin
                HALTED = 1'b1;
                if (!HALT_REQ) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_LOCKED: begin
                w_state_next = ST_LOCKED;
            end
            default: begin
                w_state_next = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_pc    <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == ST_EXECUTE) begin
            r_carry <= ALU_CARRY;
            if (!LOAD_IN[LD_PC]) begin
                r_pc <= IMM;
            end else begin
                r_pc <= r_pc + PC_W'(1);
            end
            if (w_self_jump) begin
                r_done <= 1'b1;
            end
        end
    end

    assign PC         = r_pc;
    assign CARRY_FLAG = r_carry;
    assign DONE       = r_done;

endmodule

// File: tb/tb_td4_run_control.sv
module tb_td4_run_control;

    logic       CLK = 1'b0;
    logic       N_RESET = 1'b0;
    logic       RUN_MODE = 1'b0;
    logic       STEP = 1'b0;
    logic       HALT_REQ = 1'b0;
    logic [3:0] LOAD_IN = 4'b1111;
    logic [3:0] IMM = 4'd0;
    logic       ALU_CARRY = 1'b0;
    logic [3:0] PC;
    logic [3:0] LOAD_N_EN;
    logic       EXEC;
    logic       CARRY_FLAG;
    logic       HALTED;
    logic       DONE;

    td4_run_control #(.TICK_DIV(10), .DIV_W(24)) dut (
        .CLK        (CLK),
        .N_RESET    (N_RESET),
        .RUN_MODE   (RUN_MODE),
        .STEP       (STEP),
        .HALT_REQ   (HALT_REQ),
        .LOAD_IN    (LOAD_IN),
        .IMM        (IMM),
        .ALU_CARRY  (ALU_CARRY),
        .PC         (PC),
        .LOAD_N_EN  (LOAD_N_EN),
        .EXEC       (EXEC),
        .CARRY_FLAG (CARRY_FLAG),
        .HALTED     (HALTED),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int exec_cnt = 0;
    logic [7:0] sb[$];   // {pc at execute, expected LOAD_N_EN}

    typedef struct {
        logic [3:0] load_in;
        logic [3:0] imm;
        logic       carry;
        logic [3:0] exp_pc;
        logic       exp_carry;
        logic       exp_done;
    } vec_t;

    vec_t vecs[8];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard consumer: every execute window must match the oldest expectation.
    always @(negedge CLK) begin
        if (EXEC === 1'b1) begin
            logic [7:0] e;
            exec_cnt++;
            $display("exec: cycle=%0d pc=%0d load_n_en=%b", cyc, PC, LOAD_N_EN);
            check("sb_expected_exec", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_pc", 32'(PC), 32'(e[7:4]));
                check("sb_load_n_en", 32'(LOAD_N_EN), 32'(e[3:0]));
            end
        end
    end

    task automatic wait_exec(input int max_edges, output int edges, output bit found);
        edges = 0;
        found = 1'b0;
        for (int i = 0; i < max_edges && !found; i++) begin
            @(posedge CLK);
            #1;
            edges++;
            if (EXEC === 1'b1) found = 1'b1;
        end
    endtask

    task automatic step_exec(input logic [3:0] pc_before, input logic [3:0] ld, input int hold);
        int  edges;
        bit  found;
        sb.push_back({pc_before, ld});
        @(posedge CLK);
        #1;
        STEP = 1'b1;
        wait_exec(8, edges, found);
        check("step_exec_seen", 32'(found), 1);
        check("step_latency", 32'(edges), 3);
        @(posedge CLK);
        #1;
        check("exec_one_cycle", 32'(EXEC), 0);
        check("load_idle_after", 32'(LOAD_N_EN), 32'hF);
        repeat (hold) @(posedge CLK);
        #1;
        STEP = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  edges;
        bit  found;
        int  t_prev;
        int  cnt0;
        logic [3:0] model_pc;

        vecs[0] = '{4'b1110, 4'd0,  1'b1, 4'd3,  1'b1, 1'b0};
        vecs[1] = '{4'b0111, 4'd5,  1'b0, 4'd5,  1'b0, 1'b0};
        vecs[2] = '{4'b0111, 4'd9,  1'b1, 4'd9,  1'b1, 1'b0};
        vecs[3] = '{4'b1011, 4'd0,  1'b0, 4'd10, 1'b0, 1'b0};
        vecs[4] = '{4'b0111, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
        vecs[5] = '{4'b1101, 4'd3,  1'b0, 4'd0,  1'b0, 1'b0};
        vecs[6] = '{4'b0111, 4'd7,  1'b0, 4'd7,  1'b0, 1'b0};
        vecs[7] = '{4'b0111, 4'd7,  1'b1, 4'd7,  1'b1, 1'b1};

        // ---------------- reset state, run mode cadence ----------------
        RUN_MODE = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        N_RESET = 1'b1;
        check("rst_pc", 32'(PC), 0);
        check("rst_exec", 32'(EXEC), 0);
        check("rst_load_n_en", 32'(LOAD_N_EN), 32'hF);
        check("rst_carry", 32'(CARRY_FLAG), 0);
        check("rst_halted", 32'(HALTED), 0);
        check("rst_done", 32'(DONE), 0);

        for (int k = 0; k < 17; k++) sb.push_back({4'(k), 4'b1111});
        t_prev = 0;
        for (int k = 0; k < 17; k++) begin
            wait_exec(25, edges, found);
            check("run_exec_seen", 32'(found), 1);
            if (k > 0) check("run_interval", 32'(cyc - t_prev), 10);
            t_prev = cyc;
        end

        // ---------------- halt coinciding with a tick ----------------
        repeat (9) @(posedge CLK);
        #1;
        HALT_REQ = 1'b1;
        @(posedge CLK);
        #1;
        check("halt_halted", 32'(HALTED), 1);
        check("halt_no_exec", 32'(EXEC), 0);
        check("halt_pc", 32'(PC), 1);
        repeat (2) @(posedge CLK);
        #1;
        HALT_REQ = 1'b0;
        @(posedge CLK);
        #1;
        check("unhalt_halted", 32'(HALTED), 0);
        sb.push_back({4'd1, 4'b1111});
        wait_exec(20, edges, found);
        check("resume_exec_seen", 32'(found), 1);
        check("resume_edges", 32'(edges), 7);
        RUN_MODE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("resume_pc", 32'(PC), 2);

        // ---------------- step mode ----------------
        N_RESET = 1'b0;
        @(posedge CLK);
        #1;
        N_RESET = 1'b1;
        LOAD_IN = 4'b1111;
        cnt0 = exec_cnt;
        step_exec(4'd0, 4'b1111, 50);
        check("step_single_exec", 32'(exec_cnt - cnt0), 1);
        check("step1_pc", 32'(PC), 1);
        step_exec(4'd1, 4'b1111, 5);
        check("step2_pc", 32'(PC), 2);

        model_pc = 4'd2;
        for (int v = 0; v < 8; v++) begin
            LOAD_IN   = vecs[v].load_in;
            IMM       = vecs[v].imm;
            ALU_CARRY = vecs[v].carry;
            step_exec(model_pc, vecs[v].load_in, 4);
            check($sformatf("vec%0d_pc", v), 32'(PC), 32'(vecs[v].exp_pc));
            check($sformatf("vec%0d_carry", v), 32'(CARRY_FLAG), 32'(vecs[v].exp_carry));
            check($sformatf("vec%0d_done", v), 32'(DONE), 32'(vecs[v].exp_done));
            model_pc = vecs[v].exp_pc;
        end

        // ---------------- locked after self-jump ----------------
        cnt0 = exec_cnt;
        HALT_REQ = 1'b1;
        STEP = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        STEP = 1'b0;
        repeat (80) @(posedge CLK);
        #1;
        check("locked_no_exec", 32'(exec_cnt - cnt0), 0);
        check("locked_pc", 32'(PC), 7);
        check("locked_done", 32'(DONE), 1);
        check("locked_halted", 32'(HALTED), 0);
        HALT_REQ = 1'b0;
        N_RESET = 1'b0;
        @(posedge CLK);
        #1;
        N_RESET = 1'b1;
        check("unlock_pc", 32'(PC), 0);
        check("unlock_done", 32'(DONE), 0);

        // ---------------- reset during EXECUTE with jump pending ----------------
        LOAD_IN = 4'b1111;
        ALU_CARRY = 1'b0;
        step_exec(4'd0, 4'b1111, 4);
        LOAD_IN = 4'b0111;
        IMM = 4'd12;
        ALU_CARRY = 1'b1;
        sb.push_back({4'd1, 4'b0111});
        @(posedge CLK);
        #1;
        STEP = 1'b1;
        wait_exec(8, edges, found);
        check("rstx_exec_seen", 32'(found), 1);
        N_RESET = 1'b0;
        STEP = 1'b0;
        @(posedge CLK);
        #1;
        N_RESET = 1'b1;
        check("rstx_pc", 32'(PC), 0);
        check("rstx_carry", 32'(CARRY_FLAG), 0);
        check("rstx_load_n_en", 32'(LOAD_N_EN), 32'hF);
        check("rstx_exec", 32'(EXEC), 0);
        cnt0 = exec_cnt;
        repeat (10) @(posedge CLK);
        #1;
        check("rstx_quiet", 32'(exec_cnt - cnt0), 0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/td4_run_control.md
Name: td4_run_control

Overview:
Run/step sequencer for the 4-bit TD4 core. It owns the program counter and the carry flag, and decides when an instruction executes: free-running at a divided rate, or one instruction per STEP button press. It gates the decoder's active-low register-load strobes into one-cycle execute windows. It also detects the self-jump idiom, which marks the end of a program.

Parameters:
TICK_DIV, 10, clock cycles per execute tick in run mode (legal range 2..2^DIV_W-1)
DIV_W, 24, divider counter width

Ports:
CLK  in  1  system clock, rising edge
N_RESET  in  1  synchronous active-low reset
RUN_MODE  in  1  1 = free run from divider; 0 = single-step via STEP
STEP  in  1  raw step button level, asynchronous to CLK
HALT_REQ  in  1  level; pauses execution while high
LOAD_IN  in  4  decoder load strobes, active-low; [3] = PC load (jump)
IMM  in  4  instruction immediate (jump target)
ALU_CARRY  in  1  adder carry-out for the current instruction
PC  out  4  program counter (ROM address)
LOAD_N_EN  out  4  gated load enables, active-low, to registers A/B/OUT ([2:0]); bit 3 mirrors the jump
EXEC  out  1  one-cycle execute strobe
CARRY_FLAG  out  1  registered carry, feeds the decoder
HALTED  out  1  high while paused by HALT_REQ
DONE  out  1  sticky; a self-jump was executed

Behaviour:
- Reset (N_RESET=0 at a CLK edge): PC=0, CARRY_FLAG=0, EXEC=0, LOAD_N_EN=4'b1111, HALTED=0, DONE=0, divider=0, step synchronizer/edge flops=0, state=WAIT. Reset wins over every other event, including an in-flight EXECUTE (no PC or flag update that cycle).
- States:
  - WAIT: idle until a tick arrives.
  - EXECUTE: lasts exactly 1 cycle.
  - PAUSE: entered from WAIT when HALT_REQ=1.
  - LOCKED: terminal until reset.
- Tick, run mode: divider counts 0..TICK_DIV-1 and wraps to 0. Tick pulses for 1 cycle when count==TICK_DIV-1.
- Tick, step mode: STEP passes through a 2-flop synchronizer plus an edge flop. A tick pulses on a synchronized rising edge. Latency is 3 CLK edges from STEP rising to tick.
- Divider is held at 0 while RUN_MODE=0. Any RUN_MODE change clears the divider and discards a pending step edge.
- WAIT transitions:
  - HALT_REQ=1 -> PAUSE, HALTED=1. Halt wins over a same-cycle tick, and that tick is dropped.
  - Otherwise tick -> EXECUTE.
- PAUSE transitions:
  - HALT_REQ=0 -> WAIT, HALTED=0.
  - Ticks and step edges arriving in PAUSE are dropped, not queued.
- EXECUTE outputs (combinational from state): EXEC=1 and LOAD_N_EN=LOAD_IN. In every other state EXEC=0 and LOAD_N_EN=4'b1111.
- EXECUTE updates, at the closing edge:
  - CARRY_FLAG <= ALU_CARRY, updated on every instruction.
  - If LOAD_IN[3]==0: PC <= IMM. Otherwise PC <= PC+1, 4-bit wrap 15->0.
  - If LOAD_IN[3]==0 and IMM==PC: DONE <= 1 and next state = LOCKED. Otherwise next state = WAIT.
- LOCKED: PC frozen, EXEC never asserts, and HALT_REQ is ignored (HALTED stays 0). Exit is by reset only.
- A tick or step edge that coincides with EXECUTE is dropped. There is at most one instruction per tick, and back-to-back EXECUTE cycles are impossible.
- The divider keeps counting through EXECUTE and PAUSE, so the run-mode cadence does not drift.

Decomposition:
- Shared package td4_pkg holds:
  - the state encoding (WAIT, EXECUTE, PAUSE, LOCKED);
  - widths PC_W=4 and LOAD_W=4;
  - load-bit indices LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3;
  - LOAD_IDLE=4'b1111.
- Sub-module td4_tick_gen holds the divider, the STEP synchronizer and edge detector, and the RUN_MODE-change clear. It outputs a single TICK pulse.
- td4_run_control holds the FSM, PC, CARRY_FLAG and DONE.

Test Plan:
- Reset, then RUN_MODE=1, TICK_DIV=10, LOAD_IN=4'b1111 -> EXEC pulses every 10 cycles; PC goes 0,1,2...15,0; LOAD_N_EN=1111 throughout.
- RUN_MODE=0, STEP held high for 50 cycles, then low -> exactly one EXEC, 3 edges after the rise; PC 0->1; a second press gives PC=2.
- PC=5, LOAD_IN=4'b0111, IMM=9, ALU_CARRY=1 at EXEC -> PC=9, CARRY_FLAG=1, LOAD_N_EN=0111 for that one cycle only.
- PC=7, LOAD_IN=4'b0111, IMM=7 -> DONE=1, state LOCKED, no further EXEC for 100 cycles, PC stays 7; N_RESET low for 1 edge -> PC=0, DONE=0.
- HALT_REQ rises in the same cycle as a tick -> no EXEC, HALTED=1, PC unchanged. HALT_REQ falls -> HALTED=0, and execution resumes on the next tick.
- N_RESET asserted during the EXECUTE cycle with a jump pending (IMM=12) -> PC=0, CARRY_FLAG=0, LOAD_N_EN=1111 on the following cycle.
